// File: rtl/am_envelope_demod.sv
// Streaming AM envelope demodulator: rectify, moving-average over 2^LOG2_LEN samples,
// left-align to the DAC width, then optional decimation and leaky-integrator DC removal.
module am_envelope_demod #(
    parameter int IN_W     = 8,
    parameter int OUT_W    = 14,
    parameter int LOG2_LEN = 5,
    parameter int DECIM    = 1,
    parameter int DC_SHIFT = 10
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  ad_data,
    input  logic             dc_block_en,
    output logic             out_valid,
    output logic [OUT_W-1:0] da_data,
    output logic             env_ready
);

    localparam int LEN = 1 << LOG2_LEN;
    localparam int RW  = IN_W - 1;
    localparam int SW  = RW + LOG2_LEN;
    localparam int DW  = OUT_W + DC_SHIFT;
    localparam int CW  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int FW  = LOG2_LEN + 1;

    // Valid semantics: each stage valid bit marks its data registers as holding a
    // sample this cycle; there is no ready, so every stage advances unconditionally.
    logic                s1_valid, s2_valid, s3_valid;
    logic [RW-1:0]       rect, s1_rect, s1_oldest;
    logic [LOG2_LEN-1:0] wr_ptr, s1_ptr;
    logic [RW-1:0]       buffer [LEN];
    logic [SW-1:0]       sum;
    logic [SW+OUT_W-1:0] sum_wide;
    logic [OUT_W-1:0]    env_next, s3_env;
    logic [DW-1:0]       dc;
    logic [OUT_W-1:0]    dc_int;
    logic signed [DW:0]  dc_diff, dc_step;
    logic [OUT_W+1:0]    blk;
    logic [OUT_W-1:0]    blk_sat;
    logic [CW-1:0]       dec_cnt;
    logic [FW-1:0]       fill;
    logic                unused_bits;

    // Magnitude of a negative sample via the low bits of its two's complement;
    // the most negative code has no positive twin and is clamped.
    always_comb begin
        rect = ad_data[IN_W-1] ? (~ad_data[RW-1:0] + RW'(1)) : ad_data[RW-1:0];
        if (ad_data == {1'b1, {RW{1'b0}}})
            rect = '1;
    end

    // S1: wr_ptr already points past any write still pending in S2, so the
    // oldest-entry read never collides with the previous sample's write.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_valid  <= 1'b0;
            s1_rect   <= '0;
            s1_oldest <= '0;
            s1_ptr    <= '0;
            wr_ptr    <= '0;
            fill      <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_rect   <= rect;
                s1_oldest <= buffer[wr_ptr];
                s1_ptr    <= wr_ptr;
                wr_ptr    <= wr_ptr + LOG2_LEN'(1);
                if (fill != FW'(LEN))
                    fill <= fill + FW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < LEN; i++)
                buffer[i] <= '0;
            sum      <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                buffer[s1_ptr] <= s1_rect;
                sum            <= sum + SW'(s1_rect) - SW'(s1_oldest);
            end
        end
    end

    // Appending OUT_W zeros and taking the top OUT_W bits left-aligns the sum
    // whether it is wider or narrower than the DAC.
    assign sum_wide = {sum, {OUT_W{1'b0}}};
    assign env_next = sum_wide[SW+OUT_W-1 -: OUT_W];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s3_valid <= 1'b0;
            s3_env   <= '0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid)
                s3_env <= env_next;
        end
    end

    assign dc_int  = dc[DW-1 -: OUT_W];
    assign dc_diff = $signed({1'b0, s3_env, {DC_SHIFT{1'b0}}}) - $signed({1'b0, dc});
    assign dc_step = dc_diff >>> DC_SHIFT;

    // env - dc_int + mid-scale, two guard bits: top bit = below zero, next = above full scale.
    assign blk = {2'b00, s3_env} + {3'b001, {(OUT_W-1){1'b0}}} - {2'b00, dc_int};
    always_comb begin
        if (blk[OUT_W+1])
            blk_sat = '0;
        else if (blk[OUT_W])
            blk_sat = '1;
        else
            blk_sat = blk[OUT_W-1:0];
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            out_valid <= 1'b0;
            da_data   <= '0;
            dc        <= '0;
            dec_cnt   <= '0;
        end else begin
            out_valid <= 1'b0;
            if (s3_valid) begin
                dc      <= dc + dc_step[DW-1:0];
                dec_cnt <= (dec_cnt == CW'(DECIM - 1)) ? '0 : dec_cnt + CW'(1);
                if (dec_cnt == '0) begin
                    out_valid <= 1'b1;
                    da_data   <= dc_block_en ? blk_sat : s3_env;
                end
            end
        end
    end

    assign env_ready   = (fill == FW'(LEN));
    assign unused_bits = ^{sum_wide[OUT_W-1:0], dc_step[DW]};

endmodule
